// File: rtl/main_control.sv
// Multi-cycle MIPS main control: sequences fetch, decode and execution steps
// and decodes every datapath enable and mux select from the current state.
module main_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] AluOp,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] State,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RCOMPLETE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYP:      state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_RCOMPLETE;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    AluOp       = 2'b00;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    State       = state_q;
    IllegalOp   = illegal_q;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        AluSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE:  AluSrcB = 2'b11;
      S_MEMADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      S_RCOMPLETE: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: begin
        State     = 4'd0;
        IllegalOp = 1'b0;
      end
    endcase
    // During reset present a quiet FETCH: same selects, no write strobes.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      AluOp       = 2'b00;
      AluSrcA     = 1'b0;
      AluSrcB     = 2'b01;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      State       = 4'd0;
      IllegalOp   = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control.sv
// Bench for main_control: instruction-path model checked every cycle plus
// directed per-instruction state-trace and output expectations.
module tb_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, AluOp, AluSrcB;
  logic       AluSrcA, RegWrite, RegDst, IllegalOp;
  logic [3:0] State;
  logic [15:0] word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_control dut (
    .clk(clk), .rst(rst), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .AluOp(AluOp),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .State(State), .IllegalOp(IllegalOp)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,AluOp,AluSrcA,AluSrcB,RegWrite,RegDst}
  assign word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Instruction paths after DECODE, as listed state by state.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      6'b100011: return 3;
      6'b101011: return 2;
      6'b000000: return 2;
      6'b000100: return 1;
      6'b000010: return 1;
      default:   return 0;
    endcase
  endfunction

  function automatic int path_state(input logic [5:0] op, input int k);
    case (op)
      6'b100011: return (k == 0) ? 2 : (k == 1) ? 3 : 4;
      6'b101011: return (k == 0) ? 2 : 5;
      6'b000000: return (k == 0) ? 6 : 7;
      6'b000100: return 8;
      6'b000010: return 9;
      default:   return 0;
    endcase
  endfunction

  function automatic int next_step(input int step, input int len);
    if (step == 0) return 1;
    if (step == 1) return (len > 0) ? 2 : 0;
    return (step - 1 < len) ? step + 1 : 0;
  endfunction

  function automatic logic [15:0] exp_word(input int s, input logic r);
    if (r) return 16'h0004;
    case (s)
      0: return 16'h9204;
      1: return 16'h000C;
      2: return 16'h0018;
      3: return 16'h3000;
      4: return 16'h0402;
      5: return 16'h2800;
      6: return 16'h0050;
      7: return 16'h0003;
      8: return 16'h40B0;
      9: return 16'h8100;
      default: return 16'h0000;
    endcase
  endfunction

  int         m_step = 0;
  logic [5:0] m_op = 6'd0;
  logic       m_ill = 1'b0;
  logic       started = 1'b0;

  function automatic int m_state_of(input int step, input logic [5:0] op);
    if (step == 0) return 0;
    if (step == 1) return 1;
    return path_state(op, step - 2);
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_step <= 0;
      m_ill  <= 1'b0;
    end else begin
      m_ill  <= (m_step == 1) && (path_len(Op) == 0);
      if (m_step == 1) m_op <= Op;
      m_step <= next_step(m_step, path_len((m_step == 1) ? Op : m_op));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("state", {28'd0, State}, rst ? 32'd0 : m_state_of(m_step, m_op));
      check("illegal", {31'd0, IllegalOp}, rst ? 32'd0 : {31'd0, m_ill});
      check("ctrl", {16'd0, word}, {16'd0, exp_word(m_state_of(m_step, m_op), rst)});
    end
  end

  logic [31:0] got_seq;
  logic [15:0] words [8];
  logic        first_ill, seen_rw, seen_mw;
  logic [15:0] first_word;

  task automatic run_instr(input string nm, input logic [5:0] op, input int n,
                           input logic [31:0] seq, input int rst_at);
    logic [3:0] es;
    got_seq = 32'd0;
    seen_rw = 1'b0;
    seen_mw = 1'b0;
    for (int i = 0; i < n; i++) begin
      es = seq[4*(n-1-i) +: 4];
      Op = (es == 4'd1 || es == 4'd2) ? op : 6'($urandom);
      if (i == rst_at) rst = 1'b1;
      @(negedge clk);
      got_seq = {got_seq[27:0], State};
      words[i] = word;
      if (i == 0) begin
        first_ill  = IllegalOp;
        first_word = word;
      end
      seen_rw = seen_rw | RegWrite;
      seen_mw = seen_mw | MemWrite;
      @(posedge clk);
      #2;
    end
    if (rst_at >= 0) rst = 1'b0;
    check({nm, "_seq"}, got_seq, seq);
  endtask

  initial begin
    rst = 1'b1;
    Op  = 6'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_state", {28'd0, State}, 32'd0);
    check("rst_illegal", {31'd0, IllegalOp}, 32'd0);
    check("rst_wen", {16'd0, word & 16'hDA02}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    run_instr("lw", 6'b100011, 5, 32'h01234, -1);
    check("first_fetch_wen", {16'd0, first_word & 16'h9200}, 32'h9200);
    check("memwb_rw_m2r_dst", {29'd0, words[4][1], words[4][10], words[4][0]}, 32'b110);

    run_instr("sw", 6'b101011, 4, 32'h0125, -1);
    check("sw_memwrite", {31'd0, seen_mw}, 32'd1);

    run_instr("rtype", 6'b000000, 4, 32'h0167, -1);
    check("exec_aluop", {30'd0, words[2][6:5]}, 32'b10);
    check("rcomp_regdst", {31'd0, words[3][0]}, 32'd1);

    run_instr("beq", 6'b000100, 3, 32'h018, -1);
    check("branch_ctrl", {27'd0, words[2][14], words[2][8:7], words[2][6:5]}, 32'b10101);

    run_instr("j", 6'b000010, 3, 32'h019, -1);
    check("jump_ctrl", {29'd0, words[2][15], words[2][8:7]}, 32'b110);

    run_instr("illegal", 6'b111111, 2, 32'h01, -1);
    check("illegal_quiet", {31'd0, seen_rw | seen_mw}, 32'd0);
    check("illegal_not_early", {31'd0, first_ill}, 32'd0);

    run_instr("lw2", 6'b100011, 5, 32'h01234, -1);
    check("illegal_pulse", {31'd0, first_ill}, 32'd1);

    run_instr("lw_abort", 6'b100011, 4, 32'h0120, 3);
    check("abort_no_regwrite", {31'd0, seen_rw}, 32'd0);

    run_instr("beq2", 6'b000100, 3, 32'h018, -1);
    check("post_abort_no_regwrite", {31'd0, seen_rw}, 32'd0);
    check("post_abort_fetch", {16'd0, first_word}, 32'h9204);

    run_instr("rtype2", 6'b000000, 4, 32'h0167, -1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_control.md
# main_control

Multi-cycle main control state machine for the MIPS datapath. Consumes the 6-bit opcode from the instruction register and drives every datapath enable and mux select, including the 2-bit AluOp consumed by the ALU control stage. It sequences each instruction through fetch, decode and 1–3 execution steps, and returns to fetch after each instruction.

## Interface
Parameters:
- none. State encoding is fixed; see Operation.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  opcode, IR[31:26]; sampled only in DECODE
- PCWrite  out  1  unconditional PC write enable
- PCWriteCond  out  1  PC write enable, qualified by ALU Zero outside this block
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemtoReg  out  1  register write-data select: 0 = ALUOut, 1 = MDR
- IRWrite  out  1  instruction register load
- PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- AluOp  out  2  00 = add, 01 = subtract, 10 = decode funct field
- AluSrcA  out  1  0 = PC, 1 = register A
- AluSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- RegWrite  out  1  register file write enable
- RegDst  out  1  destination select: 0 = rt, 1 = rd
- State  out  4  current state encoding, for debug and verification
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RCOMPLETE=7, BRANCH=8, JUMP=9.
- Transitions:
  - FETCH→DECODE
  - DECODE→ by Op: 100011 (lw) or 101011 (sw) → MEMADDR; 000000 (R-type) → EXECUTE; 000100 (beq) → BRANCH; 000010 (j) → JUMP; any other opcode → FETCH
  - MEMADDR→MEMREAD if Op=lw, else →MEMWRITE
  - MEMREAD→MEMWB
  - EXECUTE→RCOMPLETE
  - MEMWB, MEMWRITE, RCOMPLETE, BRANCH, JUMP → FETCH
- Encodings 10–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Outputs are Moore, decoded from State only. Any output not listed for a state is 0.
  - FETCH: MemRead=1, IRWrite=1, AluSrcB=01, AluOp=00, PCWrite=1, PCSource=00, IorD=0, AluSrcA=0
  - DECODE: AluSrcA=0, AluSrcB=11, AluOp=00
  - MEMADDR: AluSrcA=1, AluSrcB=10, AluOp=00
  - MEMREAD: MemRead=1, IorD=1
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0
  - MEMWRITE: MemWrite=1, IorD=1
  - EXECUTE: AluSrcA=1, AluSrcB=00, AluOp=10
  - RCOMPLETE: RegWrite=1, RegDst=1, MemtoReg=0
  - BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01
  - JUMP: PCWrite=1, PCSource=10
- IllegalOp is registered. It is 1 for exactly the cycle after DECODE with an unsupported Op, which is the FETCH cycle that follows.

## Timing
- Reset:
  - rst high at a rising edge sets State=FETCH and IllegalOp=0.
  - While rst is high, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
  - rst asserted in any state, mid-instruction, aborts that instruction. No write enable is asserted in the cycle rst is high.
- The first FETCH that issues writes is the first cycle with rst low.
- Latency in cycles, FETCH through the last state inclusive: lw 5, sw 4, R-type 4, beq 3, j 3, illegal opcode 2.
- Op is don't-care outside DECODE and MEMADDR. Changes to Op in other states must not affect behaviour.
- Exactly one state per cycle. There are no stalls or wait states; memory is single-cycle.

## Test plan
- Reset: hold rst high for 2 cycles → State=0, IllegalOp=0 and all six write enables 0. After release, the first cycle shows IRWrite=1, PCWrite=1 and MemRead=1.
- lw (Op=100011) → State sequence 0,1,2,3,4,0. MEMWB shows RegWrite=1, MemtoReg=1, RegDst=0.
- sw (Op=101011), then R-type (Op=000000) → sequences 0,1,2,5,0 and 0,1,6,7,0. EXECUTE shows AluOp=10; RCOMPLETE shows RegDst=1.
- beq (Op=000100) and j (Op=000010) → sequences 0,1,8,0 and 0,1,9,0. BRANCH shows PCWriteCond=1, PCSource=01, AluOp=01; JUMP shows PCWrite=1, PCSource=10.
- Illegal Op=111111 → sequence 0,1,0, with IllegalOp=1 only in the second FETCH. No RegWrite or MemWrite is asserted.
- Assert rst during MEMREAD of a lw → the next state is 0, and RegWrite is never asserted for that lw.
